zx81_tape_player: RTL
=====================

// Module: zx81_tape_player
// PURPOSE
//  Sequences the ZX81 EAR input from a stored .P image, so programs LOAD without a cassette.
//  Fetches bytes over a req/ack read port (BRAM or flash reader) and emits ROM-compatible pulses on ear.
//  Sits beside fpga_zx81 in the top level; its ear output replaces the pin-sourced ear net.
// PARAMETERS
//  HALF_CYC    1875      clk_sys cycles per pulse half (150us at 12.5MHz)
//  GAP_CYC     16250     silent cycles after each bit (1300us)
//  LEADIN_CYC  6250000   silent cycles before the name byte (0.5s)
//  TRAIL_CYC   1250000   silent cycles after the last byte (0.1s)
//  NAME_BYTE   8'hA6     single-char program name, bit7 set = last char
//  TMR_W       24        timer width; must hold max(LEADIN_CYC,TRAIL_CYC)
// PORTS
//  clk_sys   in   1   system clock
//  reset_n   in   1   synchronous active-low reset
//  start     in   1   1-cycle pulse: begin playback
//  stop      in   1   1-cycle pulse: abort playback
//  length    in   16  data byte count, sampled on accepted start
//  rd_req    out  1   read request, held until rd_ack
//  rd_addr   out  16  byte index 0..length-1, stable while rd_req=1
//  rd_ack    in   1   read data valid this cycle
//  rd_data   in   8   read byte, captured when rd_ack=1
//  ear       out  1   tape signal to core; 0 = silence
//  busy      out  1   1 from accepted start until IDLE is re-entered
//  done      out  1   1-cycle pulse on normal completion
// BEHAVIOUR
//  Reset: ear=0, rd_req=0, rd_addr=0, busy=0, done=0, state IDLE, all counters 0.
//  FSM: IDLE -> LEADIN -> NAME -> FETCH -> SHIFT -> (FETCH | TRAIL) -> DONE -> IDLE.
//  IDLE: start=1 and stop=0 latches length, sets busy next cycle and enters LEADIN.
//  LEADIN: ear=0 for LEADIN_CYC cycles, then NAME loads NAME_BYTE into the shift register and enters SHIFT.
//  SHIFT: sends 8 bits MSB first. Bit 1 = 9 pulses, bit 0 = 4 pulses.
//   Each pulse is ear=1 for HALF_CYC cycles, then ear=0 for HALF_CYC cycles.
//   After the last pulse of a bit: ear=0 for GAP_CYC cycles.
//  Bit duration = (2*HALF_CYC*npulses + GAP_CYC) cycles exactly; no idle cycles between bits or bytes.
//  After bit 0 of a byte: go to FETCH if the sent byte count is less than length, else TRAIL.
//  FETCH: rd_req=1 and rd_addr=index from the cycle FETCH is entered.
//   On the rd_ack cycle: capture rd_data; rd_req=0 next cycle; index+1; enter SHIFT.
//   ear stays 0 during FETCH. The first FETCH is overlapped by the name byte (prefetch register).
//   A fetch stall may therefore extend a gap, but never truncates a pulse.
//  length=0: name byte only, then TRAIL.
//  TRAIL: ear=0 for TRAIL_CYC cycles. DONE: done=1 for one cycle, busy=0 and IDLE next cycle.
//  stop (any state but IDLE): next cycle ear=0, rd_req=0, busy=0, state IDLE, done stays 0.
//   A pending read is abandoned; a late rd_ack is ignored.
//  start while busy: ignored. start and stop in the same cycle: stop wins.
//  reset_n=0 mid-playback: reset values on the next edge, same as a power-on reset.
//  rd_ack while rd_req=0: ignored. Index is 16-bit; length=65535 ends with index=65535, no wrap.
// STRUCTURE
//  Package zx81_tape_pkg holds:
//   state encoding (IDLE, LEADIN, NAME, FETCH, SHIFT, TRAIL, DONE);
//   PULSES_ONE=9, PULSES_ZERO=4;
//   default timing constants for 12.5MHz and 13MHz clk_sys.
//  Sub-module zx81_tape_bit_gen: input bit_val, input go; outputs ear, bit_done.
//   Owns the pulse counter and half/gap timer.
//  zx81_tape_player owns: byte FSM, shift/prefetch registers, read handshake, leadin/trail timer.
// TESTING (sim params HALF_CYC=4, GAP_CYC=20, LEADIN_CYC=10, TRAIL_CYC=6)
//  1. start, length=0 -> ear 0 for 10 cycles.
//     Then NAME 0xA6 (1,0,1,0,0,1,1,0) = 9,4,9,4,4,9,9,4 pulses, each 8 cycles.
//     Then 6 cycles silence; done is a single pulse; busy falls with it.
//  2. length=2, memory {0x00,0xFF} -> rd_addr 0 then 1, one req each.
//     Data bits: 8x4 pulses, then 8x9 pulses; total bit-time matches the formula exactly.
//  3. rd_ack delayed 50 cycles on byte 1 -> rd_req and rd_addr stable throughout.
//     Pulse widths unchanged; only the preceding gap lengthens.
//  4. stop mid-pulse (ear=1) -> next cycle ear=0, rd_req=0, busy=0, no done.
//     A later start replays from leadin and rd_addr 0.
//  5. start during playback and start+stop in IDLE -> no state change, no rd_req.
//  6. reset_n low for 1 cycle while rd_req=1 -> all outputs at reset values.
//     A stale rd_ack afterwards has no effect.

Source files
------------

// File: rtl/zx81_tape_pkg.sv
// Shared encodings and timing presets for the ZX81 .P tape player.
package zx81_tape_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEADIN,
    ST_NAME,
    ST_FETCH,
    ST_SHIFT,
    ST_TRAIL,
    ST_DONE
  } tape_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_HIGH,
    PH_LOW,
    PH_GAP
  } pulse_phase_e;

  localparam int PULSES_ONE  = 9;
  localparam int PULSES_ZERO = 4;

  // 12.5 MHz clk_sys: 150us half pulse, 1300us gap, 0.5s lead-in, 0.1s trail
  localparam int HALF_CYC_12M5   = 1875;
  localparam int GAP_CYC_12M5    = 16250;
  localparam int LEADIN_CYC_12M5 = 6250000;
  localparam int TRAIL_CYC_12M5  = 1250000;

  localparam int HALF_CYC_13M    = 1950;
  localparam int GAP_CYC_13M     = 16900;
  localparam int LEADIN_CYC_13M  = 6500000;
  localparam int TRAIL_CYC_13M   = 1300000;

  function automatic logic [3:0] pulse_count(input logic bit_val);
    return bit_val ? 4'(PULSES_ONE) : 4'(PULSES_ZERO);
  endfunction

endpackage

// File: rtl/zx81_tape_bit_gen.sv
// Emits one tape bit: n pulses of HALF_CYC high/low, then GAP_CYC silence.
// A go in the bit_done cycle starts the next bit with no idle cycle.
module zx81_tape_bit_gen
  import zx81_tape_pkg::*;
#(
  parameter int HALF_CYC = HALF_CYC_12M5,
  parameter int GAP_CYC  = GAP_CYC_12M5
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic abort_i,
  input  logic go_i,
  input  logic bit_val_i,
  output logic ear_o,
  output logic bit_done_o
);

  localparam int BT_MAX = (GAP_CYC > HALF_CYC) ? GAP_CYC : HALF_CYC;
  localparam int BT_W   = $clog2(BT_MAX + 1);

  pulse_phase_e    phase_q, phase_d;
  logic [BT_W-1:0] tmr_q, tmr_d;
  logic [3:0]      pcnt_q, pcnt_d;
  logic            tmr_zero;

  assign tmr_zero   = (tmr_q == '0);
  assign bit_done_o = (phase_q == PH_GAP) && tmr_zero;
  assign ear_o      = (phase_q == PH_HIGH);

  always_comb begin
    phase_d = phase_q;
    tmr_d   = tmr_q;
    pcnt_d  = pcnt_q;
    case (phase_q)
      PH_HIGH: begin
        if (tmr_zero) begin
          phase_d = PH_LOW;
          tmr_d   = BT_W'(HALF_CYC - 1);
        end else begin
          tmr_d = tmr_q - BT_W'(1);
        end
      end
      PH_LOW: begin
        if (!tmr_zero) begin
          tmr_d = tmr_q - BT_W'(1);
        end else if (pcnt_q > 4'd1) begin
          phase_d = PH_HIGH;
          tmr_d   = BT_W'(HALF_CYC - 1);
          pcnt_d  = pcnt_q - 4'd1;
        end else begin
          phase_d = PH_GAP;
          tmr_d   = BT_W'(GAP_CYC - 1);
        end
      end
      PH_GAP: begin
        if (tmr_zero) phase_d = PH_IDLE;
        else          tmr_d   = tmr_q - BT_W'(1);
      end
      default: ;
    endcase
    if (go_i && ((phase_q == PH_IDLE) || bit_done_o)) begin
      phase_d = PH_HIGH;
      tmr_d   = BT_W'(HALF_CYC - 1);
      pcnt_d  = pulse_count(bit_val_i);
    end
    if (abort_i) begin
      phase_d = PH_IDLE;
      tmr_d   = '0;
      pcnt_d  = '0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      phase_q <= PH_IDLE;
      tmr_q   <= '0;
      pcnt_q  <= '0;
    end else begin
      phase_q <= phase_d;
      tmr_q   <= tmr_d;
      pcnt_q  <= pcnt_d;
    end
  end

endmodule

// File: rtl/zx81_tape_player.sv
// Plays a stored .P image onto EAR: lead-in, name byte, data bytes MSB first, trail.
// Next data byte is prefetched while the current byte shifts; a slow read only stretches the gap.
module zx81_tape_player
  import zx81_tape_pkg::*;
#(
  parameter int         HALF_CYC   = HALF_CYC_12M5,
  parameter int         GAP_CYC    = GAP_CYC_12M5,
  parameter int         LEADIN_CYC = LEADIN_CYC_12M5,
  parameter int         TRAIL_CYC  = TRAIL_CYC_12M5,
  parameter logic [7:0] NAME_BYTE  = 8'hA6,
  parameter int         TMR_W      = 24
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] length,
  output logic        rd_req,
  output logic [15:0] rd_addr,
  input  logic        rd_ack,
  input  logic [7:0]  rd_data,
  output logic        ear,
  output logic        busy,
  output logic        done
);

  tape_state_e      state_q, state_d;
  logic [15:0]      len_q, len_d;
  logic [15:0]      idx_q, idx_d;
  logic [15:0]      sent_q, sent_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       pf_q, pf_d;
  logic             pf_vld_q, pf_vld_d;
  logic             req_q, req_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  logic bg_go, bg_bit, bg_abort, bg_bit_done, bg_ear;
  logic active, load_pf;

  zx81_tape_bit_gen #(
    .HALF_CYC (HALF_CYC),
    .GAP_CYC  (GAP_CYC)
  ) u_bit_gen (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .abort_i    (bg_abort),
    .go_i       (bg_go),
    .bit_val_i  (bg_bit),
    .ear_o      (bg_ear),
    .bit_done_o (bg_bit_done)
  );

  assign active = (state_q == ST_LEADIN) || (state_q == ST_NAME) ||
                  (state_q == ST_SHIFT)  || (state_q == ST_FETCH);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    sent_d   = sent_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    pf_d     = pf_q;
    pf_vld_d = pf_vld_q;
    req_d    = req_q;
    tmr_d    = tmr_q;
    bg_go    = 1'b0;
    bg_bit   = 1'b0;
    bg_abort = 1'b0;
    load_pf  = 1'b0;

    // Read port runs alongside the byte FSM, keeping the prefetch register full.
    if (req_q && rd_ack) begin
      pf_d     = rd_data;
      pf_vld_d = 1'b1;
      req_d    = 1'b0;
      idx_d    = idx_q + 16'd1;
    end else if (active && !req_q && !pf_vld_q && (idx_q < len_q)) begin
      req_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          len_d    = length;
          idx_d    = '0;
          sent_d   = '0;
          pf_vld_d = 1'b0;
          req_d    = 1'b0;
          // NAME takes one more silent cycle, so lead-in totals LEADIN_CYC
          tmr_d    = TMR_W'(LEADIN_CYC - 2);
          state_d  = ST_LEADIN;
        end
      end
      ST_LEADIN: begin
        if (tmr_q == '0) state_d = ST_NAME;
        else             tmr_d   = tmr_q - TMR_W'(1);
      end
      ST_NAME: begin
        shreg_d  = NAME_BYTE;
        bitcnt_d = 3'd7;
        bg_go    = 1'b1;
        bg_bit   = NAME_BYTE[7];
        state_d  = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bg_bit_done) begin
          if (bitcnt_q != 3'd0) begin
            shreg_d  = shreg_q << 1;
            bitcnt_d = bitcnt_q - 3'd1;
            bg_go    = 1'b1;
            bg_bit   = shreg_q[6];
          end else if (sent_q < len_q) begin
            if (pf_vld_q) load_pf = 1'b1;
            else          state_d = ST_FETCH;
          end else begin
            tmr_d   = TMR_W'(TRAIL_CYC - 1);
            state_d = ST_TRAIL;
          end
        end
      end
      ST_FETCH: begin
        if (pf_vld_q) load_pf = 1'b1;
      end
      ST_TRAIL: begin
        if (tmr_q == '0) state_d = ST_DONE;
        else             tmr_d   = tmr_q - TMR_W'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (load_pf) begin
      shreg_d  = pf_q;
      pf_vld_d = 1'b0;
      bitcnt_d = 3'd7;
      sent_d   = sent_q + 16'd1;
      bg_go    = 1'b1;
      bg_bit   = pf_q[7];
      state_d  = ST_SHIFT;
    end

    if (stop && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      req_d    = 1'b0;
      pf_vld_d = 1'b0;
      bg_abort = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      idx_q    <= '0;
      sent_q   <= '0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      pf_q     <= '0;
      pf_vld_q <= 1'b0;
      req_q    <= 1'b0;
      tmr_q    <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      sent_q   <= sent_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      pf_q     <= pf_d;
      pf_vld_q <= pf_vld_d;
      req_q    <= req_d;
      tmr_q    <= tmr_d;
    end
  end

  assign rd_req  = req_q;
  assign rd_addr = idx_q;
  assign ear     = bg_ear;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);

endmodule
